// File: rtl/blowfish_core_iter.sv
// Iterative Blowfish engine: one Feistel round per clock, shared encrypt/decrypt path.
// P-array and S-boxes are loadable memories, writable only while the core is idle.
module blowfish_core_iter #(
  parameter int ROUNDS = 16,
  parameter int PAW    = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           p_we,
  input  logic [PAW-1:0] p_addr,
  input  logic [31:0]    p_wdata,
  input  logic           s_we,
  input  logic [9:0]     s_addr,
  input  logic [31:0]    s_wdata,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           mode,
  input  logic [63:0]    din,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [63:0]    dout,
  output logic           busy
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_p [0:(1<<PAW)-1];
  logic [31:0]     r_s [0:1023];
  logic [31:0]     r_l, r_r;
  logic            r_mode;
  logic [PAW-1:0]  r_cnt;
  logic [63:0]     r_dout;
  logic            r_ov;

  logic            w_mem_open;
  logic            w_last;
  logic [PAW-1:0]  w_k;
  logic [31:0]     w_lx, w_rx, w_f;
  logic [31:0]     w_pl, w_pr;

  assign w_mem_open = (r_state == S_IDLE);
  assign in_ready   = (r_state == S_IDLE) && !rst;
  assign out_valid  = r_ov;
  assign dout       = r_dout;
  assign busy       = (r_state != S_IDLE);

  // Tables are not reset; out-of-range P writes are dropped.
  always_ff @(posedge clk) begin
    if (w_mem_open && p_we && (p_addr <= PAW'(ROUNDS + 1)))
      r_p[p_addr] <= p_wdata;
    if (w_mem_open && s_we)
      r_s[s_addr] <= s_wdata;
  end

  // Decrypt walks the P-array from the top down.
  assign w_last = (r_cnt == PAW'(ROUNDS - 1));
  assign w_k    = r_mode ? (PAW'(ROUNDS + 1) - r_cnt) : r_cnt;
  assign w_lx   = r_l ^ r_p[w_k];
  assign w_f    = ((r_s[{2'd0, w_lx[31:24]}] + r_s[{2'd1, w_lx[23:16]}])
                  ^ r_s[{2'd2, w_lx[15:8]}]) + r_s[{2'd3, w_lx[7:0]}];
  assign w_rx   = r_r ^ w_f;
  assign w_pl   = r_mode ? r_p[PAW'(0)] : r_p[PAW'(ROUNDS + 1)];
  assign w_pr   = r_mode ? r_p[PAW'(1)] : r_p[PAW'(ROUNDS)];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ov    <= 1'b0;
      r_dout  <= 64'h0;
      r_cnt   <= '0;
      r_l     <= 32'h0;
      r_r     <= 32'h0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_l    <= din[63:32];
            r_r    <= din[31:0];
            r_mode <= mode;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          // Last round: no swap, output whitening folded into the same edge.
          if (w_last) begin
            r_dout <= {w_lx ^ w_pl, w_rx ^ w_pr};
            r_ov   <= 1'b1;
          end else begin
            r_l   <= w_rx;
            r_r   <= w_lx;
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) r_ov <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/blowfish_core_iter.md
Name: blowfish_core_iter

Overview:
- Parametrised, iterative Blowfish engine. One Feistel round per clock; encrypt and decrypt share one datapath, selected per block.
- P-array and S-boxes live in internal memories. Software or a key-schedule block loads them through write ports, so any key can be used without resynthesis.
- Sits between the block-cipher wrapper and the bus interface. Replaces the fixed decrypt-only core; valid/ready handshakes replace free-running din/dout.

Parameters:
- ROUNDS, 16, Feistel round count. Must be even, 2..16. P-array holds ROUNDS+2 words.
- PAW, 5, P-array address width. Must satisfy 2^PAW >= ROUNDS+2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- p_we  in  1  P-array write strobe
- p_addr  in  PAW  P-array word index, 0..ROUNDS+1
- p_wdata  in  32  P-array write data
- s_we  in  1  S-box write strobe
- s_addr  in  10  [9:8] selects S-box 0..3; [7:0] selects entry
- s_wdata  in  32  S-box write data
- in_valid  in  1  input block valid
- in_ready  out  1  core can accept a block
- mode  in  1  0 = encrypt, 1 = decrypt; sampled with din
- din  in  64  input block; [63:32] = L, [31:0] = R
- out_valid  out  1  dout valid
- out_ready  in  1  consumer accepts dout
- dout  out  64  result block; [63:32] = L, [31:0] = R
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, out_valid=0, dout=64'h0, round counter=0.
  - in_ready=0 while rst is high; it goes to 1 on the first cycle after rst falls.
  - P/S memory contents are not reset; they are undefined until written.
- Memory writes:
  - Accepted only in IDLE: p_we or s_we high at a clk edge writes the addressed word.
  - Ignored in RUN and DONE.
  - p_addr > ROUNDS+1 is ignored.
  - A write takes effect for any block accepted on a later edge.
  - A write in the same cycle as an acceptance edge is also legal; the new value is seen from that block's first round onward.
  - Memories are read combinationally.
- F function:
  - F(x) = ((S0[x[31:24]] + S1[x[23:16]]) ^ S2[x[15:8]]) + S3[x[7:0]].
  - All additions are mod 2^32.
- State machine IDLE -> RUN -> DONE -> IDLE:
  - IDLE: in_ready=1. On in_valid && in_ready: latch L=din[63:32], R=din[31:0], latch mode, clear counter i, go to RUN.
  - RUN, round i, one edge per round:
    - k = i for encrypt, k = ROUNDS+1-i for decrypt.
    - L' = L ^ P[k]; R' = R ^ F(L'); then swap, so L = R', R = L'.
    - i increments each round.
  - On round i = ROUNDS-1 the same edge also finishes the block:
    - Skip the final swap.
    - XOR P[ROUNDS] into R and P[ROUNDS+1] into L for encrypt; XOR P[1] into R and P[0] into L for decrypt.
    - Write {L,R} to dout, set out_valid=1, go to DONE.
  - DONE: dout and out_valid are held stable until out_valid && out_ready at an edge. Then out_valid=0 and state goes to IDLE. dout keeps its last value.
- Timing:
  - Latency is ROUNDS edges from the acceptance edge to out_valid high.
  - in_ready is low in RUN and DONE, so there is no accept in the cycle the output is consumed.
  - Throughput is one block per ROUNDS+2 cycles when out_ready is tied high.
- Boundary conditions:
  - in_valid with in_ready low: the block is not consumed. The upstream holds din, mode and in_valid.
  - rst during RUN or DONE: the block is aborted with no output; reset values apply on the next edge.
  - mode and din changes after acceptance have no effect on the block in flight.
  - out_ready high while out_valid is low has no effect.

Test Plan:
- All P/S = 0, ROUNDS=16, encrypt din=64'h0123456789ABCDEF -> dout=64'h89ABCDEF01234567, out_valid exactly 16 cycles after the accept edge.
- All S = 0; P[16]=32'h000000FF, P[17]=32'hFF000000, others 0; encrypt din=0 -> dout=64'hFF000000000000FF. Decrypt that result -> dout=0.
- Load P/S from the standard expansion of the all-zero key; encrypt din=0 -> dout=64'h4EF997456198DD78. Decrypt 64'h4EF997456198DD78 -> dout=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> dout stable, in_ready=0, and a p_we issued meanwhile leaves the P-array unchanged. Raise out_ready -> IDLE next cycle.
- Assert rst at round 7 -> next cycle out_valid=0, dout=0, busy=0. A new block after reset completes correctly with the table left unmodified.
- Back-to-back: 8 random blocks with alternating mode against a model, in_valid held high, out_ready=1 -> all match, one accept every 18 cycles.
